// File: rtl/ram_bank_read_mux.sv
// Pipelined read front-end for NUM_BANKS RAM banks with in-order response FIFO.
// Optional RAM_BANK_ERR_EN adds an rsp_err flag for out-of-range bank indices.
module ram_bank_read_mux #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int NUM_BANKS  = 2,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int BANK_W    = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [BANK_W-1:0]           req_bank,
  input  logic [ADDR_W-1:0]           req_addr,
  output logic [NUM_BANKS-1:0]        bank_rd_en,
  output logic [ADDR_W-1:0]           bank_addr,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_rd_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [BANK_W-1:0]           rsp_bank
`ifdef RAM_BANK_ERR_EN
  ,
  output logic                        rsp_err
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TAG_N = RD_LAT + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  logic                 acc;
  logic                 pop;
  logic                 wr;
  logic [DATA_W-1:0]    wr_data;

  logic                 ready_q, ready_d;
  logic [NUM_BANKS-1:0] en_q, en_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]     cred_q, cred_d;

  logic                 tag_v_q [TAG_N];
  logic                 tag_v_d [TAG_N];
  logic [BANK_W-1:0]    tag_b_q [TAG_N];
  logic [BANK_W-1:0]    tag_b_d [TAG_N];

  logic [DATA_W-1:0]    mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]    mem_d [FIFO_DEPTH];
  logic [BANK_W-1:0]    mbank_q [FIFO_DEPTH];
  logic [BANK_W-1:0]    mbank_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wp_q, wp_d;
  logic [PTR_W-1:0]     rp_q, rp_d;
  logic [CNT_W-1:0]     fill_q, fill_d;

`ifdef RAM_BANK_ERR_EN
  logic                 req_bad;
  logic                 tag_e_q [TAG_N];
  logic                 tag_e_d [TAG_N];
  logic                 merr_q [FIFO_DEPTH];
  logic                 merr_d [FIFO_DEPTH];
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign acc       = req_valid & ready_q;
  assign rsp_valid = (fill_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign wr        = tag_v_q[RD_LAT];

  assign req_ready  = ready_q;
  assign bank_rd_en = en_q;
  assign bank_addr  = addr_q;
  assign rsp_data   = mem_q[rp_q];
  assign rsp_bank   = mbank_q[rp_q];

`ifdef RAM_BANK_ERR_EN
  assign req_bad = {1'b0, req_bank} >= (BANK_W + 1)'(NUM_BANKS);
  assign rsp_err = merr_q[rp_q];
`endif

  // Request side: bank strobe, address register and credit accounting
  always_comb begin
    en_d   = '0;
    addr_d = addr_q;
    cred_d = cred_q;
    for (int i = 0; i < NUM_BANKS; i++) begin
      en_d[i] = acc && (req_bank == BANK_W'(i));
    end
    if (acc) begin
      addr_d = req_addr;
    end
    if (acc && !pop) begin
      cred_d = cred_q + CNT_W'(1);
    end else if (pop && !acc) begin
      cred_d = cred_q - CNT_W'(1);
    end
    ready_d = (cred_d < DEPTH_C);
  end

  // Tag pipeline: follows each read through the RAM latency
  always_comb begin
    tag_v_d[0] = acc;
    tag_b_d[0] = req_bank;
`ifdef RAM_BANK_ERR_EN
    tag_e_d[0] = req_bad;
`endif
    for (int k = 1; k < TAG_N; k++) begin
      tag_v_d[k] = tag_v_q[k-1];
      tag_b_d[k] = tag_b_q[k-1];
`ifdef RAM_BANK_ERR_EN
      tag_e_d[k] = tag_e_q[k-1];
`endif
    end
  end

  // Return mux: pick the tagged bank's slice, zero for an unknown bank
  always_comb begin
    wr_data = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (tag_b_q[RD_LAT] == BANK_W'(i)) begin
        wr_data = bank_rd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Response FIFO: show-ahead, simultaneous push and pop
  always_comb begin
    mem_d   = mem_q;
    mbank_d = mbank_q;
`ifdef RAM_BANK_ERR_EN
    merr_d  = merr_q;
`endif
    wp_d    = wp_q;
    rp_d    = rp_q;
    fill_d  = fill_q;
    if (wr) begin
      mem_d[wp_q]   = wr_data;
      mbank_d[wp_q] = tag_b_q[RD_LAT];
`ifdef RAM_BANK_ERR_EN
      merr_d[wp_q]  = tag_e_q[RD_LAT];
`endif
      wp_d          = ptr_inc(wp_q);
    end
    if (pop) begin
      rp_d = ptr_inc(rp_q);
    end
    if (wr && !pop) begin
      fill_d = fill_q + CNT_W'(1);
    end else if (pop && !wr) begin
      fill_d = fill_q - CNT_W'(1);
    end
  end

  // State registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      en_q    <= '0;
      addr_q  <= '0;
      cred_q  <= '0;
      tag_v_q <= '{default: 1'b0};
      tag_b_q <= '{default: '0};
      mem_q   <= '{default: '0};
      mbank_q <= '{default: '0};
`ifdef RAM_BANK_ERR_EN
      tag_e_q <= '{default: 1'b0};
      merr_q  <= '{default: 1'b0};
`endif
      wp_q    <= '0;
      rp_q    <= '0;
      fill_q  <= '0;
    end else begin
      ready_q <= ready_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      cred_q  <= cred_d;
      tag_v_q <= tag_v_d;
      tag_b_q <= tag_b_d;
      mem_q   <= mem_d;
      mbank_q <= mbank_d;
`ifdef RAM_BANK_ERR_EN
      tag_e_q <= tag_e_d;
      merr_q  <= merr_d;
`endif
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: tb/tb_ram_bank_read_mux.sv
// Scoreboard bench for ram_bank_read_mux: 3 banks, latency 1, depth 4.
// Expected responses are queued on accept and compared when popped.
module tb_ram_bank_read_mux;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NB = 3;
  localparam int BW = 2;
  localparam int FD = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic [BW-1:0]  req_bank;
  logic [AW-1:0]  req_addr;
  logic [NB-1:0]  bank_rd_en;
  logic [AW-1:0]  bank_addr;
  logic [NB*DW-1:0] bank_rd_data;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [DW-1:0]  rsp_data;
  logic [BW-1:0]  rsp_bank;
`ifdef RAM_BANK_ERR_EN
  logic           rsp_err;
`endif

  int chk = 0;
  int err = 0;

  logic [DW-1:0] bmem [NB][256];
  logic [DW-1:0] rd_r [NB];
  logic [DW+BW:0] sbq [$];
  logic [DW+BW:0] exp_e;

  always #5 clk = ~clk;

  ram_bank_read_mux #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB), .RD_LAT(1), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_bank(req_bank), .req_addr(req_addr),
    .bank_rd_en(bank_rd_en), .bank_addr(bank_addr),
    .bank_rd_data(bank_rd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_bank(rsp_bank)
`ifdef RAM_BANK_ERR_EN
    , .rsp_err(rsp_err)
`endif
  );

  // RAM model: one-cycle read, garbage when not enabled
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      rd_r[i] <= bank_rd_en[i] ? bmem[i][bank_addr] : DW'($urandom);
    end
  end

  always_comb begin
    bank_rd_data = '0;
    for (int i = 0; i < NB; i++) begin
      bank_rd_data[i*DW +: DW] = rd_r[i];
    end
  end

  // Scoreboard: push expected on accept, compare on pop
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        chk++;
        if (sbq.size() == 0) begin
          err++;
          $display("FAIL spurious_rsp got data=%h bank=%0d, none expected",
                   rsp_data, rsp_bank);
        end else begin
          exp_e = sbq.pop_front();
          if (rsp_data !== exp_e[DW-1:0] || rsp_bank !== exp_e[DW+BW-1:DW]
`ifdef RAM_BANK_ERR_EN
              || rsp_err !== exp_e[DW+BW]
`endif
             ) begin
            err++;
            $display("FAIL rsp got data=%h bank=%0d, expected data=%h bank=%0d err=%0b",
                     rsp_data, rsp_bank, exp_e[DW-1:0], exp_e[DW+BW-1:DW],
                     exp_e[DW+BW]);
          end
        end
      end
      if (req_valid && req_ready) begin
        if (int'(req_bank) < NB)
          sbq.push_back({1'b0, req_bank, bmem[req_bank][req_addr]});
        else
          sbq.push_back({1'b1, req_bank, DW'(0)});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 60 && sbq.size() != 0; i++) step();
    step();
    check("drain_empty", sbq.size(), 0);
  endtask

  int acc_n;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_bank = '0; req_addr = '0;
    rsp_ready = 1'b0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 256; a++) bmem[b][a] = DW'($urandom);
    bmem[1][8'h12] = 8'hA5;
    step(); step();
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rd_en", int'(bank_rd_en), 0);
    check("rst_bank_addr", int'(bank_addr), 0);
    check("rst_rsp_data", int'(rsp_data), 0);
    check("rst_rsp_bank", int'(rsp_bank), 0);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", int'(req_ready), 1);

    // single read
    req_valid = 1'b1; req_bank = 2'd1; req_addr = 8'h12; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    check("single_rd_en", int'(bank_rd_en), 2);
    check("single_addr", int'(bank_addr), 8'h12);
    step();
    check("single_no_early", int'(rsp_valid), 0);
    step();
    check("single_valid", int'(rsp_valid), 1);
    check("single_data", int'(rsp_data), 8'hA5);
    check("single_bank", int'(rsp_bank), 1);
    drain();

    // out-of-range bank
    req_valid = 1'b1; req_bank = 2'd3; req_addr = 8'h40;
    step();
    req_valid = 1'b0;
    check("oor_rd_en", int'(bank_rd_en), 0);
    drain();

    // streaming
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_bank = BW'(i % 2); req_addr = AW'($urandom);
      check("stream_ready", int'(req_ready), 1);
      step();
    end
    req_valid = 1'b0;
    step(); step(); step();
    check("stream_done", sbq.size(), 0);

    // backpressure
    rsp_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_bank = BW'($urandom_range(0, NB - 1));
      req_addr = AW'($urandom);
      if (req_ready) acc_n++;
      step();
    end
    req_valid = 1'b0;
    check("bp_accepts", acc_n, FD);
    check("bp_ready_low", int'(req_ready), 0);
    step(); step(); step();
    check("bp_head_valid", int'(rsp_valid), 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("bp_ready_back", int'(req_ready), 1);
    check("bp_queue_left", sbq.size(), FD - 1);

    // sustained push/pop with full credits
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req_valid = 1'b1; req_bank = BW'($urandom_range(0, NB - 1));
      req_addr = AW'($urandom);
      step();
    end
    drain();

    // randomized traffic including out-of-range banks
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom);
      req_bank = BW'($urandom);
      req_addr = AW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // reset with reads in flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_bank = BW'($urandom_range(0, NB - 1));
      req_addr = AW'($urandom);
      step();
    end
    req_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check("midrst_rsp_valid", int'(rsp_valid), 0);
    check("midrst_req_ready", int'(req_ready), 0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    step();
    check("midrst_ready_back", int'(req_ready), 1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("midrst_no_stale", int'(rsp_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
